mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single synchronous-read memory port between the CPU and a second master (DMA/loader/scanout).
- Issues at most one memory command per cycle and gives same-cycle grants.
- Routes 1-cycle-latency read data back with a per-port valid strobe.
- Sits between the requesters and the block RAM.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_wait_ctr.sv | 40 ++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

   localparam int POLICY_RR    = 0;
   localparam int POLICY_FIXED = 1;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   localparam int STATS_W = 16;

   // Outstanding read: which port gets the data returning next cycle.
   typedef struct packed {
      logic valid;
      logic port;
   } rd_tag_t;

   // Saturating increment for statistics counters.
   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating starvation counter: counts waiting cycles, flags when LIMIT is reached.
// Latency: expiry flag is registered state, visible the cycle after the count reaches LIMIT.
// Backpressure: none; clr wins over inc.
module arb_wait_ctr #(
   parameter int WIDTH = 8,
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic expired_o
);

   localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Next count: clear first, otherwise increment until the limit and hold there.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIM)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto one synchronous-read memory port; optional stats via MEM_ARB_STATS_EN.
// Latency: same-cycle grant and command; read data returns one cycle after the read grant.
// Backpressure: a requester holds req until its gnt; loser simply waits, no queuing.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AWIDTH     = 16,
   parameter int DWIDTH     = 16,
   parameter int POLICY     = 0,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [AWIDTH-1:0] p0_addr,
   input  logic [DWIDTH-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [AWIDTH-1:0] p1_addr,
   input  logic [DWIDTH-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DWIDTH-1:0] rdata,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_wr,
   output logic              mem_rd,
   input  logic [DWIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   input  logic               stats_clr,
   output logic [STATS_W-1:0] p0_grants,
   output logic [STATS_W-1:0] p1_grants,
   output logic [STATS_W-1:0] conflicts
`endif
);

   logic    last_q, last_d;
   rd_tag_t tag_q, tag_d;
   logic    starve_exp;
   logic    gnt0, gnt1;
   logic    any_gnt;
   logic    sel_we;

   // Starvation guard exists only for fixed priority; round-robin cannot starve.
   if (POLICY == POLICY_FIXED) begin : g_starve
      arb_wait_ctr #(
         .WIDTH (8),
         .LIMIT (STARVE_MAX)
      ) u_wait_ctr (
         .clk       (clk),
         .rst_n     (rst_n),
         .inc_i     (p1_req & ~gnt1),
         .clr_i     (gnt1 | ~p1_req),
         .expired_o (starve_exp)
      );
   end else begin : g_no_starve
      assign starve_exp = 1'b0;
   end

   // Winner selection from current requests and registered pointer/counter; no grants in reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         if (POLICY == POLICY_FIXED) begin
            if (p1_req && (starve_exp || !p0_req)) begin
               gnt1 = 1'b1;
            end else if (p0_req) begin
               gnt0 = 1'b1;
            end
         end else begin
            if (p0_req && p1_req) begin
               if (last_q == PORT_CPU) gnt1 = 1'b1;
               else                    gnt0 = 1'b1;
            end else if (p0_req) begin
               gnt0 = 1'b1;
            end else if (p1_req) begin
               gnt1 = 1'b1;
            end
         end
      end
   end

   assign any_gnt = gnt0 | gnt1;
   assign p0_gnt  = gnt0;
   assign p1_gnt  = gnt1;

   // Command mux: port 0 fields by default so idle cycles carry no strobes; all zero in reset.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      sel_we    = 1'b0;
      if (rst_n) begin
         mem_addr  = gnt1 ? p1_addr  : p0_addr;
         mem_wdata = gnt1 ? p1_wdata : p0_wdata;
         sel_we    = gnt1 ? p1_we    : p0_we;
      end
   end

   assign mem_wr = any_gnt &  sel_we;
   assign mem_rd = any_gnt & ~sel_we;

   // Next pointer and read tag.
   always_comb begin
      last_d      = any_gnt ? (gnt1 ? PORT_AUX : PORT_CPU) : last_q;
      tag_d.valid = mem_rd;
      tag_d.port  = gnt1 ? PORT_AUX : PORT_CPU;
   end

   // Pointer starts at port 1 so port 0 wins the first tie; a pending tag dies in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_AUX;
         tag_q  <= '0;
      end else begin
         last_q <= last_d;
         tag_q  <= tag_d;
      end
   end

   assign p0_rvalid = tag_q.valid && (tag_q.port == PORT_CPU);
   assign p1_rvalid = tag_q.valid && (tag_q.port == PORT_AUX);
   assign rdata     = mem_rdata;

`ifdef MEM_ARB_STATS_EN
   logic [STATS_W-1:0] p0_grants_q, p1_grants_q, conflicts_q;

   // Saturating grant/conflict counters; synchronous clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_grants_q <= '0;
         p1_grants_q <= '0;
         conflicts_q <= '0;
      end else if (stats_clr) begin
         p0_grants_q <= '0;
         p1_grants_q <= '0;
         conflicts_q <= '0;
      end else begin
         if (gnt0)             p0_grants_q <= sat_inc(p0_grants_q);
         if (gnt1)             p1_grants_q <= sat_inc(p1_grants_q);
         if (p0_req && p1_req) conflicts_q <= sat_inc(conflicts_q);
      end
   end

   assign p0_grants = p0_grants_q;
   assign p1_grants = p1_grants_q;
   assign conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance and fixed-priority (STARVE_MAX=3) instance on shared stimulus.
// Latency: checks grants/commands in the grant cycle, rvalid one cycle later.
// Backpressure: requesters hold req until granted.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;
   logic        stats_clr;

   logic        rr_p0_gnt, rr_p1_gnt, rr_p0_rv, rr_p1_rv, rr_wr, rr_rd;
   logic [15:0] rr_rdata, rr_addr, rr_wdata;
   logic        fp_p0_gnt, fp_p1_gnt, fp_p0_rv, fp_p1_rv, fp_wr, fp_rd;
   logic [15:0] fp_rdata, fp_addr, fp_wdata;
`ifdef MEM_ARB_STATS_EN
   logic [15:0] rr_g0, rr_g1, rr_cf, fp_g0, fp_g1, fp_cf;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .POLICY(0), .STARVE_MAX(8)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(rr_p0_gnt), .p0_rvalid(rr_p0_rv),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(rr_p1_gnt), .p1_rvalid(rr_p1_rv),
      .rdata(rr_rdata), .mem_addr(rr_addr), .mem_wdata(rr_wdata),
      .mem_wr(rr_wr), .mem_rd(rr_rd), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
      , .stats_clr(stats_clr), .p0_grants(rr_g0), .p1_grants(rr_g1), .conflicts(rr_cf)
`endif
   );

   mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .POLICY(1), .STARVE_MAX(3)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rv),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rv),
      .rdata(fp_rdata), .mem_addr(fp_addr), .mem_wdata(fp_wdata),
      .mem_wr(fp_wr), .mem_rd(fp_rd), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
      , .stats_clr(stats_clr), .p0_grants(fp_g0), .p1_grants(fp_g1), .conflicts(fp_cf)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
      p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
   endtask

   // Advance to the next cycle's input window.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      stats_clr = 1'b0;
      mem_rdata = 16'h0;
      drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      @(negedge clk);
      // Reset state: request present, nothing may come out
      chk("rst_p0_gnt", 32'(rr_p0_gnt), 32'd0);
      chk("rst_mem_rd", 32'(rr_rd),     32'd0);
      chk("rst_mem_wr", 32'(rr_wr),     32'd0);
      chk("rst_p0_rv",  32'(rr_p0_rv),  32'd0);
      chk("rst_addr",   32'(rr_addr),   32'd0);
      p0_req = 1'b0;
      rst_n  = 1'b1;

      // Single read from port 0
      step();
      drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      chk("rd_p0_gnt", 32'(rr_p0_gnt), 32'd1);
      chk("rd_p1_gnt", 32'(rr_p1_gnt), 32'd0);
      chk("rd_mem_rd", 32'(rr_rd),     32'd1);
      chk("rd_addr",   32'(rr_addr),   32'h0010);
      step();
      drive(0, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
      mem_rdata = 16'hBEEF;
      @(negedge clk);
      chk("rd_p0_rv", 32'(rr_p0_rv), 32'd1);
      chk("rd_p1_rv", 32'(rr_p1_rv), 32'd0);
      chk("rd_rdata", 32'(rr_rdata), 32'hBEEF);
      chk("rd_idle",  32'(rr_rd),    32'd0);

      // Round-robin, both reading for 6 cycles
      step();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         drive(1, 0, 16'h0100, 16'h0, 1, 0, 16'h0200, 16'h0);
         mem_rdata = 16'hA000 + 16'(i);
         @(negedge clk);
         chk("rr_p0_gnt", 32'(rr_p0_gnt), 32'(i % 2 == 0));
         chk("rr_p1_gnt", 32'(rr_p1_gnt), 32'(i % 2 == 1));
         chk("rr_mem_rd", 32'(rr_rd),     32'd1);
         chk("rr_addr",   32'(rr_addr),   (i % 2 == 0) ? 32'h0100 : 32'h0200);
         if (i > 0) begin
            chk("rr_p0_rv", 32'(rr_p0_rv), 32'((i - 1) % 2 == 0));
            chk("rr_p1_rv", 32'(rr_p1_rv), 32'((i - 1) % 2 == 1));
         end
      end
      step();
      drive(0, 0, 16'h0100, 16'h0, 0, 0, 16'h0200, 16'h0);
      stats_clr = 1'b1;
      mem_rdata = 16'h5A5A;
      @(negedge clk);
      chk("rr_tail_p1_rv", 32'(rr_p1_rv),                32'd1);
      chk("rr_tail_p0_rv", 32'(rr_p0_rv),                32'd0);
      chk("rr_tail_rdata", 32'(rr_rdata),                32'h5A5A);
      chk("idle_gnts",     32'({rr_p0_gnt, rr_p1_gnt}), 32'd0);
      chk("idle_strobes",  32'({rr_wr, rr_rd}),         32'd0);
      chk("idle_addr",     32'(rr_addr),                 32'h0100);

      // Five conflict cycles for the statistics counters
      step();
      stats_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 16'h0100, 16'h0, 1, 0, 16'h0200, 16'h0);
         @(negedge clk);
         chk("st_p0_gnt", 32'(rr_p0_gnt), 32'(i % 2 == 0));
         step();
      end
      drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
`ifdef MEM_ARB_STATS_EN
      chk("st_conflicts", 32'(rr_cf), 32'd5);
      chk("st_p0_grants", 32'(rr_g0), 32'd3);
      chk("st_p1_grants", 32'(rr_g1), 32'd2);
`endif
      step();
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      @(negedge clk);
`ifdef MEM_ARB_STATS_EN
      chk("st_clr_conf", 32'(rr_cf), 32'd0);
      chk("st_clr_g0",   32'(rr_g0), 32'd0);
      chk("st_clr_g1",   32'(rr_g1), 32'd0);
`endif

      // Fixed priority with STARVE_MAX=3: p0,p0,p0,p1 repeating
      step();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step();
         drive(1, 0, 16'h0100, 16'h0, 1, 0, 16'h0200, 16'h0);
         @(negedge clk);
         chk("fp_p0_gnt", 32'(fp_p0_gnt), 32'(i % 4 != 3));
         chk("fp_p1_gnt", 32'(fp_p1_gnt), 32'(i % 4 == 3));
         chk("fp_addr",   32'(fp_addr),   (i % 4 == 3) ? 32'h0200 : 32'h0100);
         if (i > 0) chk("fp_p1_rv", 32'(fp_p1_rv), 32'((i - 1) % 4 == 3));
      end
      // Port 1 alone wins immediately under fixed priority
      step();
      drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0300, 16'h0);
      @(negedge clk);
      chk("fp_p1_alone", 32'(fp_p1_gnt), 32'd1);

      // Port 1 write alone
      step();
      do_reset();
      step();
      drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h00FF, 16'h1234);
      @(negedge clk);
      chk("wr_p1_gnt", 32'(rr_p1_gnt), 32'd1);
      chk("wr_p0_gnt", 32'(rr_p0_gnt), 32'd0);
      chk("wr_mem_wr", 32'(rr_wr),     32'd1);
      chk("wr_mem_rd", 32'(rr_rd),     32'd0);
      chk("wr_wdata",  32'(rr_wdata),  32'h1234);
      chk("wr_addr",   32'(rr_addr),   32'h00FF);
      step();
      drive(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      chk("wr_no_rv1", 32'(rr_p1_rv),  32'd0);
      chk("wr_no_rv0", 32'(rr_p0_rv),  32'd0);
      chk("p0_alone1", 32'(rr_p0_gnt), 32'd1);
      step();
      @(negedge clk);
      chk("p0_alone2", 32'(rr_p0_gnt), 32'd1);
      chk("p0_alone2_rv", 32'(rr_p0_rv), 32'd1);

      // Read granted, then reset before the return cycle
      step();
      do_reset();
      step();
      drive(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      chk("mr_p0_gnt", 32'(rr_p0_gnt), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_gnt_in_rst", 32'(rr_p0_gnt),       32'd0);
      chk("mr_str_in_rst", 32'({rr_wr, rr_rd}),  32'd0);
      step();
      chk("mr_rv_in_rst",  32'(rr_p0_rv),        32'd0);
      p0_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      @(negedge clk);
      chk("mr_rv_after",   32'(rr_p0_rv),        32'd0);
      chk("mr_str_after",  32'({rr_wr, rr_rd}),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
